// File: rtl/snn_aer_pkg.sv
// Shared AER types: handshake FSM state encodings and the event type-field width.
package snn_aer_pkg;

  // Width of the event-type field carried in the top bits of an event address.
  localparam int AER_TYPE_W = 2;

  // Input-side handshake states.
  typedef enum logic {
    S_IN_IDLE = 1'b0,
    S_IN_HOLD = 1'b1
  } aer_in_state_t;

  // Output-side handshake states.
  typedef enum logic [1:0] {
    S_OUT_IDLE = 2'd0,
    S_OUT_REQ  = 2'd1,
    S_OUT_REL  = 2'd2
  } aer_out_state_t;

endpackage

// File: rtl/aer_sync_fifo_mem.sv
// Event storage: DEPTH x ADDR_W register array, one synchronous write port,
// one asynchronous read port. Contents are not reset; validity is tracked by
// the pointers in the parent.
module aer_sync_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 11
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [ADDR_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [ADDR_W-1:0]        rdata
);

  logic [ADDR_W-1:0] mem [DEPTH];

  // Write the accepted event into its slot.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/aer_out_event_fifo.sv
// Output event FIFO between the core-event arbiter and the next layer's AERIN.
// Accepts events with a 4-phase handshake, replays them in order with a second
// 4-phase handshake, and counts accepted events per sample.
//
// Handshake semantics (both sides): REQ rises with ADDR stable; ACK rises to
// take the event; REQ falls; ACK falls. Input side: the event is captured on
// the edge where IN_REQ is seen high in IN_IDLE with the FIFO not full.
// Output side: the entry is popped on the edge where OUT_ACK is seen high
// while OUT_REQ is asserted; OUT_REQ is never raised while OUT_ACK is high.
module aer_out_event_fifo
  import snn_aer_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     IN_REQ,
  input  logic [ADDR_W-1:0]        IN_ADDR,
  output logic                     IN_ACK,
  output logic                     OUT_REQ,
  output logic [ADDR_W-1:0]        OUT_ADDR,
  input  logic                     OUT_ACK,
  input  logic                     CNT_CLR,
  output logic [CNT_W-1:0]         EVT_CNT,
  output logic [$clog2(DEPTH):0]   FIFO_LVL,
  output logic                     FULL,
  output logic                     EMPTY,
  output aer_in_state_t            in_state_dbg,
  output aer_out_state_t           out_state_dbg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  aer_in_state_t  in_state, in_state_nx;
  aer_out_state_t out_state, out_state_nx;

  logic [PTR_W-1:0]  wptr, rptr;
  logic [LVL_W-1:0]  lvl_q, lvl_nx;
  logic              full_q, empty_q;
  logic [ADDR_W-1:0] head_addr, out_addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              push, pop, out_load;

  // Push and pop are decided from registered flags only, so a pop at FULL
  // only frees a slot for the input side on the following cycle.
  assign push     = (in_state == S_IN_IDLE) && IN_REQ && !full_q;
  assign pop      = (out_state == S_OUT_REQ) && OUT_ACK;
  assign out_load = (out_state == S_OUT_IDLE) && !empty_q && !OUT_ACK;

  aer_sync_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (IN_ADDR),
    .raddr (rptr),
    .rdata (head_addr)
  );

  // Input FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_state <= S_IN_IDLE;
    else     in_state <= in_state_nx;
  end

  // Input FSM next state: capture, then hold ACK until REQ drops.
  always_comb begin
    in_state_nx = in_state;
    unique case (in_state)
      S_IN_IDLE: if (push)    in_state_nx = S_IN_HOLD;
      S_IN_HOLD: if (!IN_REQ) in_state_nx = S_IN_IDLE;
      default:                in_state_nx = S_IN_IDLE;
    endcase
  end

  // Input FSM outputs.
  always_comb begin
    IN_ACK = (in_state == S_IN_HOLD);
  end

  // Output FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_state <= S_OUT_IDLE;
    else     out_state <= out_state_nx;
  end

  // Output FSM next state: present head, pop on ACK, wait for ACK release.
  always_comb begin
    out_state_nx = out_state;
    unique case (out_state)
      S_OUT_IDLE: if (out_load) out_state_nx = S_OUT_REQ;
      S_OUT_REQ:  if (OUT_ACK)  out_state_nx = S_OUT_REL;
      S_OUT_REL:  if (!OUT_ACK) out_state_nx = S_OUT_IDLE;
      default:                  out_state_nx = S_OUT_IDLE;
    endcase
  end

  // Output FSM outputs.
  always_comb begin
    OUT_REQ = (out_state == S_OUT_REQ);
  end

  // Occupancy after this edge's push/pop; simultaneous push and pop cancel.
  always_comb begin
    lvl_nx = lvl_q;
    unique case ({push, pop})
      2'b10:   lvl_nx = lvl_q + LVL_W'(1);
      2'b01:   lvl_nx = lvl_q - LVL_W'(1);
      default: lvl_nx = lvl_q;
    endcase
  end

  // Pointers, occupancy flags and the presented output address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      lvl_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      out_addr_q <= '0;
    end else begin
      if (push)     wptr <= wptr + PTR_W'(1);
      if (pop)      rptr <= rptr + PTR_W'(1);
      lvl_q   <= lvl_nx;
      full_q  <= (lvl_nx == LVL_FULL);
      empty_q <= (lvl_nx == '0);
      if (out_load) out_addr_q <= head_addr;
    end
  end

  // Accepted-event counter: clear wins over count, but a coincident push counts as the first event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (CNT_CLR) begin
      cnt_q <= push ? CNT_W'(1) : '0;
    end else if (push && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign OUT_ADDR      = out_addr_q;
  assign EVT_CNT       = cnt_q;
  assign FIFO_LVL      = lvl_q;
  assign FULL          = full_q;
  assign EMPTY         = empty_q;
  assign in_state_dbg  = in_state;
  assign out_state_dbg = out_state;

endmodule

// File: tb/tb_aer_out_event_fifo.sv
// Bench for aer_out_event_fifo: queue-based reference model checked every
// cycle, an in-order scoreboard on the downstream side, and literal checks.
module tb_aer_out_event_fifo;
  import snn_aer_pkg::*;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              IN_REQ  = 1'b0;
  logic [ADDR_W-1:0] IN_ADDR = '0;
  logic              OUT_ACK = 1'b0;
  logic              CNT_CLR = 1'b0;
  logic              IN_ACK, OUT_REQ, FULL, EMPTY;
  logic [ADDR_W-1:0] OUT_ADDR;
  logic [CNT_W-1:0]  EVT_CNT;
  logic [LVL_W-1:0]  FIFO_LVL;
  aer_in_state_t     in_state_dbg;
  aer_out_state_t    out_state_dbg;

  // Narrow-counter instance shares all inputs; only its counter is checked.
  logic              IN_ACK4, OUT_REQ4, FULL4, EMPTY4;
  logic [ADDR_W-1:0] OUT_ADDR4;
  logic [3:0]        EVT_CNT4;
  logic [LVL_W-1:0]  FIFO_LVL4;
  aer_in_state_t     in_state_dbg4;
  aer_out_state_t    out_state_dbg4;

  aer_out_event_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .IN_REQ(IN_REQ), .IN_ADDR(IN_ADDR), .IN_ACK(IN_ACK),
    .OUT_REQ(OUT_REQ), .OUT_ADDR(OUT_ADDR), .OUT_ACK(OUT_ACK), .CNT_CLR(CNT_CLR),
    .EVT_CNT(EVT_CNT), .FIFO_LVL(FIFO_LVL), .FULL(FULL), .EMPTY(EMPTY),
    .in_state_dbg(in_state_dbg), .out_state_dbg(out_state_dbg)
  );

  aer_out_event_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .IN_REQ(IN_REQ), .IN_ADDR(IN_ADDR), .IN_ACK(IN_ACK4),
    .OUT_REQ(OUT_REQ4), .OUT_ADDR(OUT_ADDR4), .OUT_ACK(OUT_ACK), .CNT_CLR(CNT_CLR),
    .EVT_CNT(EVT_CNT4), .FIFO_LVL(FIFO_LVL4), .FULL(FULL4), .EMPTY(EMPTY4),
    .in_state_dbg(in_state_dbg4), .out_state_dbg(out_state_dbg4)
  );

  // ---------------- checking helpers ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The FIFO is a queue; handshake progress is tracked as plain flags.
  logic [ADDR_W-1:0] m_q[$];
  bit                m_in_hold   = 1'b0;
  int                m_out_phase = 0;   // 0 waiting, 1 requesting, 2 releasing
  logic [ADDR_W-1:0] m_out_addr  = '0;
  int                m_cnt       = 0;
  int                m_cnt4      = 0;
  bit                m_push, m_pop;
  int                m_n;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_in_hold   = 1'b0;
        m_out_phase = 0;
        m_out_addr  = '0;
        m_cnt       = 0;
        m_cnt4      = 0;
      end else begin
        m_n    = m_q.size();
        m_push = !m_in_hold && IN_REQ && (m_n < DEPTH);
        m_pop  = (m_out_phase == 1) && OUT_ACK;
        if (!m_in_hold) m_in_hold = m_push;
        else if (!IN_REQ) m_in_hold = 1'b0;
        case (m_out_phase)
          0: if (m_n != 0 && !OUT_ACK) begin m_out_addr = m_q[0]; m_out_phase = 1; end
          1: if (OUT_ACK) m_out_phase = 2;
          default: if (!OUT_ACK) m_out_phase = 0;
        endcase
        if (m_pop)  void'(m_q.pop_front());
        if (m_push) m_q.push_back(IN_ADDR);
        if (CNT_CLR) begin
          m_cnt  = m_push ? 1 : 0;
          m_cnt4 = m_push ? 1 : 0;
        end else if (m_push) begin
          if (m_cnt  < 65535) m_cnt++;
          if (m_cnt4 < 15)    m_cnt4++;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      chk("cyc_in_ack",   IN_ACK,   m_in_hold);
      chk("cyc_out_req",  OUT_REQ,  m_out_phase == 1);
      chk("cyc_out_addr", OUT_ADDR, m_out_addr);
      chk("cyc_evt_cnt",  EVT_CNT,  m_cnt);
      chk("cyc_evt_cnt4", EVT_CNT4, m_cnt4);
      chk("cyc_lvl",      FIFO_LVL, m_q.size());
      chk("cyc_full",     FULL,     m_q.size() == DEPTH);
      chk("cyc_empty",    EMPTY,    m_q.size() == 0);
      chk("lvl_bound",    FIFO_LVL <= DEPTH, 1'b1);
    end
  end

  // ---------------- scoreboard / downstream responder ----------------
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] got_log[$];
  bit ack_en = 1'b0;
  int dmin   = 0;
  int dmax   = 0;

  initial begin
    logic [ADDR_W-1:0] got;
    int d, n;
    forever begin
      @(negedge clk);
      if (OUT_REQ && ack_en && !rst) begin
        d = $urandom_range(dmax, dmin);
        repeat (d) @(negedge clk);
        got = OUT_ADDR;
        OUT_ACK = 1'b1;
        got_log.push_back(got);
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL sb_extra: got %0h with nothing expected", got);
        end else begin
          chk("sb_order", got, exp_q.pop_front());
        end
        n = 0;
        while (OUT_REQ && n < 20) begin @(negedge clk); n++; end
        chk("out_req_drop", OUT_REQ, 1'b0);
        OUT_ACK = 1'b0;
      end
    end
  end

  // ---------------- upstream driver tasks ----------------
  task automatic begin_event(input logic [ADDR_W-1:0] a, input bit clr);
    IN_ADDR = a;
    IN_REQ  = 1'b1;
    CNT_CLR = clr;
    @(negedge clk);
    CNT_CLR = 1'b0;
  endtask

  task automatic finish_event(input logic [ADDR_W-1:0] a);
    int n = 0;
    while (!IN_ACK && n < 400) begin @(negedge clk); n++; end
    chk("in_ack_rise", IN_ACK, 1'b1);
    if (IN_ACK) exp_q.push_back(a);
    IN_REQ = 1'b0;
    n = 0;
    while (IN_ACK && n < 20) begin @(negedge clk); n++; end
    chk("in_ack_fall", IN_ACK, 1'b0);
  endtask

  task automatic send_event(input logic [ADDR_W-1:0] a);
    begin_event(a, 1'b0);
    finish_event(a);
  endtask

  task automatic drain();
    int n = 0;
    while (!(exp_q.size() == 0 && EMPTY && !OUT_REQ && !OUT_ACK) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_done", exp_q.size(), 0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ack"},  IN_ACK,   1'b0);
    chk({tag, "_out_req"}, OUT_REQ,  1'b0);
    chk({tag, "_out_addr"}, OUT_ADDR, 0);
    chk({tag, "_evt_cnt"}, EVT_CNT,  0);
    chk({tag, "_evt_cnt4"}, EVT_CNT4, 0);
    chk({tag, "_lvl"},     FIFO_LVL, 0);
    chk({tag, "_empty"},   EMPTY,    1'b1);
    chk({tag, "_full"},    FULL,     1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [ADDR_W-1:0] sent[$];
    logic [ADDR_W-1:0] a;

    repeat (3) @(negedge clk);
    chk_reset_values("rst");
    rst = 1'b0;
    @(negedge clk);

    // Single event, downstream acknowledges 2 cycles after OUT_REQ.
    dmin = 2; dmax = 2; ack_en = 1'b1;
    begin_event(11'h155, 1'b0);
    chk("single_ack_latency", IN_ACK, 1'b1);
    finish_event(11'h155);
    chk("single_out_req", OUT_REQ, 1'b1);
    chk("single_out_addr", OUT_ADDR, 11'h155);
    drain();
    chk("single_evt_cnt", EVT_CNT, 1);
    chk("single_empty", EMPTY, 1'b1);

    // Counter clear alone, and coincident with the third push.
    dmin = 0; dmax = 3;
    CNT_CLR = 1'b1;
    @(negedge clk);
    CNT_CLR = 1'b0;
    chk("clr_alone", EVT_CNT, 0);
    send_event(11'h001);
    send_event(11'h002);
    chk("cnt_two", EVT_CNT, 2);
    begin_event(11'h003, 1'b1);
    finish_event(11'h003);
    chk("clr_with_push", EVT_CNT, 1);
    send_event(11'h004);
    chk("cnt_after_clr_push", EVT_CNT, 2);
    drain();

    // Fill with downstream stalled, then release.
    ack_en = 1'b0;
    got_log.delete();
    for (int i = 0; i < 16; i++) send_event(ADDR_W'(i));
    repeat (3) @(negedge clk);
    chk("fill_lvl", FIFO_LVL, 16);
    chk("fill_full", FULL, 1'b1);
    begin_event(11'd16, 1'b0);
    repeat (4) @(negedge clk);
    chk("full_backpressure_ack", IN_ACK, 1'b0);
    chk("full_flag_held", FULL, 1'b1);
    dmin = 0; dmax = 0; ack_en = 1'b1;
    finish_event(11'd16);
    drain();
    chk("fill_out_count", got_log.size(), 17);
    for (int i = 0; i < 17; i++) begin
      if (i < got_log.size()) chk("fill_order", got_log[i], i);
    end
    chk("fill_evt_cnt", EVT_CNT, 19);
    chk("sat_evt_cnt4", EVT_CNT4, 15);

    // Wrap-around with random downstream delay and bursty input.
    dmin = 0; dmax = 5;
    got_log.delete();
    sent.delete();
    for (int i = 0; i < 40; i++) begin
      a = ADDR_W'($urandom_range(2047, 0));
      sent.push_back(a);
      send_event(a);
      if (i >= 20) repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    drain();
    chk("wrap_count", got_log.size(), 40);
    for (int i = 0; i < 40; i++) begin
      if (i < got_log.size()) chk("wrap_seq", got_log[i], sent[i]);
    end

    // Reset in the middle of an output handshake with 5 entries buffered.
    ack_en = 1'b0;
    for (int i = 0; i < 5; i++) send_event(ADDR_W'(11'h100 + i));
    repeat (2) @(negedge clk);
    chk("pre_rst_out_req", OUT_REQ, 1'b1);
    chk("pre_rst_lvl", FIFO_LVL, 5);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_values("midrst");
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    ack_en = 1'b1;
    dmin = 0; dmax = 2;
    got_log.delete();
    send_event(11'h2AA);
    drain();
    chk("post_rst_count", got_log.size(), 1);
    if (got_log.size() > 0) chk("post_rst_first", got_log[0], 11'h2AA);
    chk("post_rst_evt_cnt", EVT_CNT, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
